// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW reference reader: FSM encodings,
// default read latency and the output buffer sizing rule.
package dtw_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  localparam int DEF_RD_LAT = 2;

  // Enough room for every read in flight plus one beat waiting at the head.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/dtw_ref_reader_fifo.sv
// Show-ahead synchronous FIFO holding {last, data} beats; flush empties it
// in one cycle without touching the storage.
module dtw_ref_reader_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/dtw_ref_reader.sv
// Streams reference samples 0..len-1 out of the reference memory core into a
// valid/ready sample stream, keeping reads in flight bounded by buffer space.
module dtw_ref_reader
  import dtw_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int RD_LAT           = DEF_RD_LAT
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic [ADDR_WIDTH-1:0]       ref_len_in,
  input  logic                        ref_load_done_in,
  output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
  input  logic [DATA_WIDTH-1:0]       ref_data_in,
  output logic [DATA_WIDTH-1:0]       m_data_out,
  output logic                        m_valid_out,
  output logic                        m_last_out,
  input  logic                        m_ready_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [1:0]                  dbg_state
);

  localparam int PW    = REFMEM_PTR_WIDTH;
  localparam int DEPTH = fifo_depth(RD_LAT);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'({PW{1'b1}});

  logic [1:0]          state;
  logic [PW-1:0]       issue_cnt, last_idx, len_clamp;
  logic [RD_LAT:0]     vld_pipe, lst_pipe;
  logic [CW-1:0]       fifo_cnt;
  logic [CW:0]         in_flight, occupancy;
  logic [DATA_WIDTH:0] head;
  logic                fifo_valid, pop, flush, issue, last_issue, start_ok, done_q;

  assign len_clamp  = (ref_len_in > MAX_LEN) ? '1 : ref_len_in[PW-1:0];
  assign flush      = (state != ST_IDLE) && (abort_in || !ref_load_done_in);
  assign pop        = fifo_valid && m_ready_in;
  assign start_ok   = (state == ST_IDLE) && start_in && ref_load_done_in && !abort_in;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= RD_LAT; i++) in_flight = in_flight + {{CW{1'b0}}, vld_pipe[i]};
  end

  // The beat leaving this cycle frees its slot, which keeps 1 beat/cycle
  // while still bounding reads in flight plus buffered beats to DEPTH.
  assign occupancy  = {1'b0, fifo_cnt} + in_flight - {{CW{1'b0}}, pop};
  assign issue      = (state == ST_STREAM) && !flush && (occupancy < (CW+1)'(DEPTH));
  assign last_issue = issue && (issue_cnt == last_idx);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      issue_cnt    <= '0;
      last_idx     <= '0;
      ref_addr_out <= '0;
      vld_pipe     <= '0;
      lst_pipe     <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // vld_pipe[0] marks the cycle the address is on the bus; the top
      // stage marks the cycle its data is on ref_data_in.
      if (flush) begin
        vld_pipe <= '0;
        lst_pipe <= '0;
      end else begin
        vld_pipe <= {vld_pipe[RD_LAT-1:0], issue};
        lst_pipe <= {lst_pipe[RD_LAT-1:0], last_issue};
      end
      if (issue) begin
        ref_addr_out <= issue_cnt;
        issue_cnt    <= issue_cnt + PW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            if (ref_len_in == '0) begin
              done_q <= 1'b1;
            end else begin
              state     <= ST_STREAM;
              issue_cnt <= '0;
              last_idx  <= len_clamp - PW'(1);
            end
          end
        end
        ST_STREAM: begin
          if (flush)           state <= ST_IDLE;
          else if (last_issue) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (pop && head[DATA_WIDTH]) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dtw_ref_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .flush  (flush),
    .push   (vld_pipe[RD_LAT]),
    .wdata  ({lst_pipe[RD_LAT], ref_data_in}),
    .pop    (pop),
    .rdata  (head),
    .valid  (fifo_valid),
    .count  (fifo_cnt)
  );

  assign m_data_out  = head[DATA_WIDTH-1:0];
  assign m_last_out  = head[DATA_WIDTH] & fifo_valid;
  assign m_valid_out = fifo_valid;
  assign busy_out    = (state != ST_IDLE);
  assign done_out    = done_q;
  assign dbg_state   = state;

endmodule

// File: doc/dtw_ref_reader.md
DTW_REF_READER -- requirements
Module: dtw_ref_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, reference sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, length/control word width.
REQ-003 SHALL have parameter REFMEM_PTR_WIDTH, default 20, reference memory address width.
REQ-004 SHALL have parameter RD_LAT, default 2, cycles from ref_addr_out change to matching ref_data_in.
REQ-005 SHALL use one clock and a synchronous, active-high reset: ports clk_in (in, 1, clock) and rst_in (in, 1, synchronous active-high reset).
REQ-006 SHALL have start_in  in  1  single-cycle request to stream the reference.
REQ-007 SHALL have abort_in  in  1  cancel any stream in progress.
REQ-008 SHALL have ref_len_in  in  ADDR_WIDTH  number of samples to stream.
REQ-009 SHALL have ref_load_done_in  in  1  reference memory holds valid data.
REQ-010 SHALL have ref_addr_out  out  REFMEM_PTR_WIDTH  read address to reference core.
REQ-011 SHALL have ref_data_in  in  DATA_WIDTH  read data from reference core.
REQ-012 SHALL have m_data_out  out  DATA_WIDTH, m_valid_out  out  1, m_last_out  out  1, m_ready_in  in  1: output sample stream.
REQ-013 SHALL have busy_out  out  1, done_out  out  1 (one-cycle pulse), dbg_state  out  2.

Function
REQ-014 SHALL implement FSM IDLE(0), STREAM(1), DRAIN(2); dbg_state = current state.
REQ-015 SHALL leave IDLE for STREAM only when start_in=1, ref_load_done_in=1 and ref_len_in!=0. A start_in with ref_load_done_in=0 SHALL be ignored.
REQ-016 SHALL respond to start_in with ref_load_done_in=1 and ref_len_in=0 by pulsing done_out on the next cycle, emitting no beats and staying in IDLE.
REQ-017 SHALL latch the length at start, clamped to 2^REFMEM_PTR_WIDTH-1. ref_len_in changes during a stream SHALL be ignored.
REQ-018 SHALL issue addresses 0,1,...,len-1 in order, at most one per cycle, from a registered ref_addr_out. When not issuing, ref_addr_out SHALL hold its last value.
REQ-019 SHALL issue an address only if in_flight + fifo_count < FIFO_DEPTH, where FIFO_DEPTH = RD_LAT+2 = 4 by default. Output overflow SHALL be impossible.
REQ-020 SHALL track each issued address with an RD_LAT-deep valid shift register. Exactly RD_LAT cycles after issue, it SHALL write ref_data_in into the output FIFO.
REQ-021 SHALL tag the beat read from address len-1 as last. m_last_out SHALL equal 1 only when that beat is at the head of the FIFO.
REQ-022 SHALL follow the valid/ready rule: a beat transfers when m_valid_out & m_ready_in. While stalled, m_data_out and m_last_out SHALL be held stable.
REQ-023 SHALL sustain 1 beat/cycle with m_ready_in held high. First m_valid_out SHALL rise RD_LAT+2 cycles after start_in is sampled.
REQ-024 SHALL move STREAM->DRAIN once the last address is issued, and DRAIN->IDLE when the last beat transfers. done_out SHALL pulse in the cycle after that transfer.
REQ-025 SHALL assert busy_out in STREAM and DRAIN only.
REQ-026 SHALL treat abort_in=1, or ref_load_done_in falling during STREAM/DRAIN, as an abort: next state IDLE, FIFO and in-flight flushed, m_valid_out=0 next cycle, no done_out.
REQ-027 SHALL ignore start_in outside IDLE. If abort and start arrive in the same cycle, abort SHALL win.
REQ-028 SHALL drop read data returning after an abort rather than write it to the FIFO.

Reset
REQ-029 SHALL, on rst_in=1 at a clock edge: state IDLE, ref_addr_out=0, m_valid_out=0, m_last_out=0, m_data_out=0, busy_out=0, done_out=0, counters and FIFO empty.
REQ-030 SHALL let reset mid-stream take effect at the next edge with no done_out, as for abort.

Structure
REQ-031 SHALL place FSM state encodings, default RD_LAT and the FIFO_DEPTH rule in shared package dtw_pkg.
REQ-032 SHALL implement the output buffer as sub-module dtw_ref_reader_fifo: synchronous, show-ahead, depth FIFO_DEPTH, width DATA_WIDTH+1 (data + last), with a flush input.

Verification
REQ-033 Len=8, memory[i]=i+100, m_ready_in=1 -> beats 100..107 on consecutive cycles; last on 107; done_out one cycle later.
REQ-034 Len=8, m_ready_in toggling 1,0,0,1,... -> same 8 values in order; no loss or duplication; stable data while stalled; ref_addr_out never more than 4 ahead of accepted beats.
REQ-035 start_in with ref_load_done_in=0 -> stays IDLE, no beats, no done_out. start_in with len=0 and loaded -> done_out pulse, no beats.
REQ-036 Len=16, abort_in after 5 beats accepted -> m_valid_out low next cycle, no further beats, no done_out; a new start then streams 100..115 cleanly.
REQ-037 Len=1 -> single beat 100 with m_last_out=1, then done_out. ref_len_in = 2^20+5 -> length clamped to 2^20-1.
REQ-038 rst_in asserted mid-DRAIN with m_ready_in=0 -> all outputs at reset values next cycle; no done_out.
